div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 32 bits and the iteration count at 32.
REQ-002 clk  in  1  clock; all state SHALL update on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  divide request from EX; held high by EX while the div/divu instruction occupies EX.
REQ-005 signed_div  in  1  1 = div (two's complement), 0 = divu; sampled with start.
REQ-006 op_a  in  32  dividend; sampled with start.
REQ-007 op_b  in  32  divisor; sampled with start.
REQ-008 annul  in  1  cancel request (pipeline flush/exception); has priority over start.
REQ-009 stallreq  out  1  stall request to pipeline control while a division is in progress.
REQ-010 ready  out  1  result valid.
REQ-011 result_lo  out  32  quotient (written to LO).
REQ-012 result_hi  out  32  remainder (written to HI).
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, DIVZERO, RUN and DONE.
REQ-015 In IDLE with start=1 and annul=0, the FSM SHALL go to DIVZERO if op_b==0, else latch |op_a|, |op_b| (magnitudes only when signed_div=1), the sign flags and signed_div, clear a 6-bit counter and go to RUN.
REQ-016 Operand changes after the start cycle SHALL be ignored until the next IDLE.
REQ-017 RUN SHALL be a restoring radix-2 division producing one quotient bit per cycle over a 33-bit partial remainder, for exactly 32 cycles (counter 0..31); after the cycle with counter=31 the FSM SHALL enter DONE.
REQ-018 On entry to DONE, signed_div=1 SHALL negate the quotient when the operand signs differ, and SHALL give the remainder the sign of the dividend.
REQ-019 For signed 0x80000000 / 0xFFFFFFFF the results SHALL wrap: lo=0x80000000, hi=0x00000000.
REQ-020 DIVZERO SHALL last one cycle and then enter DONE with lo=0 and hi=0.
REQ-021 DONE SHALL assert ready=1 and hold result_hi/result_lo stable; the FSM SHALL stay in DONE while start=1 and return to IDLE the cycle after start=0.
REQ-022 Outside DONE, ready SHALL be 0 and result_hi/result_lo SHALL be 0.
REQ-023 stallreq SHALL be combinational: start & ~annul & (state != DONE), so it rises in the same cycle start first appears in IDLE.
REQ-024 Latency: with start first high in cycle 0 (IDLE), ready SHALL first be 1 in cycle 33 for a nonzero divisor and in cycle 2 for a zero divisor.
REQ-025 annul=1 in any state SHALL force IDLE at the next edge, with stallreq=0 in that cycle, and SHALL produce no ready pulse.
REQ-026 If start and annul are high together in IDLE, the block SHALL remain in IDLE.
REQ-027 A new start SHALL be accepted only from IDLE; back-to-back divides SHALL require at least one cycle with start=0 (DONE to IDLE).

Reset
REQ-028 rst=1 SHALL force IDLE, clear the counter, the partial remainder and the latched operands, and drive stallreq=0, ready=0, busy=0, result_hi=0, result_lo=0.
REQ-029 rst SHALL take priority over annul and start, including mid-RUN; after rst, no stale result SHALL appear.

Verification
REQ-030 divu 100/7, start held -> stallreq 1 in cycles 0-32; cycle 33: ready=1, lo=14, hi=2, stallreq=0.
REQ-031 div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 7/-2 -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-032 div 5/0 -> ready=1 in cycle 2, lo=0, hi=0; divu 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
REQ-033 div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, no hang.
REQ-034 annul in cycle 10 of RUN -> IDLE in cycle 11, no ready pulse; new divu 9/3 then gives lo=3, hi=0.
REQ-035 rst in cycle 20 of RUN -> all outputs 0 next cycle; operand change during RUN -> result reflects the operands sampled at start.

Source files
------------

// File: rtl/div_ctrl.sv
// Multi-cycle divide controller for the EX stage: 32-iteration restoring divider
// for div/divu with stall, annul and one-cycle divide-by-zero handling.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        annul,
  output logic        stallreq,
  output logic        ready,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quot;
  logic [31:0] divisor;
  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic        sign_a;
  logic        sign_b;
  logic        signed_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic        take;
  logic [31:0] rem_step;
  logic [31:0] quot_step;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (annul) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = (op_b == 32'd0) ? DIVZERO : RUN;
        DIVZERO: state_next = DONE;
        RUN:     if (cnt == 6'd31) state_next = DONE;
        DONE:    if (!start) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Once the shifted remainder reaches the divisor the difference is below 2^32,
  // so a 32-bit subtraction yields the exact new remainder.
  always_comb begin
    abs_a     = (signed_div && op_a[31]) ? -op_a : op_a;
    abs_b     = (signed_div && op_b[31]) ? -op_b : op_b;
    shifted   = {rem, quot[31]};
    take      = (shifted >= {1'b0, divisor});
    rem_step  = take ? (shifted[31:0] - divisor) : shifted[31:0];
    quot_step = {quot[30:0], take};
    neg_q     = signed_q & (sign_a ^ sign_b);
    neg_r     = signed_q & sign_a;
    quot_fix  = neg_q ? -quot_step : quot_step;
    rem_fix   = neg_r ? -rem_step : rem_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 6'd0;
      rem      <= 32'd0;
      quot     <= 32'd0;
      divisor  <= 32'd0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      signed_q <= 1'b0;
      lo_q     <= 32'd0;
      hi_q     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !annul) begin
            lo_q <= 32'd0;
            hi_q <= 32'd0;
            if (op_b != 32'd0) begin
              cnt      <= 6'd0;
              rem      <= 32'd0;
              quot     <= abs_a;
              divisor  <= abs_b;
              sign_a   <= op_a[31];
              sign_b   <= op_b[31];
              signed_q <= signed_div;
            end
          end
        end
        DIVZERO: begin
          lo_q <= 32'd0;
          hi_q <= 32'd0;
        end
        RUN: begin
          if (!annul) begin
            rem  <= rem_step;
            quot <= quot_step;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              lo_q <= quot_fix;
              hi_q <= rem_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are masked by rst so a reset cycle never exposes stale state.
  always_comb begin
    ready     = (state == DONE) & ~rst;
    busy      = (state != IDLE) & ~rst;
    stallreq  = ~rst & start & ~annul & (state != DONE);
    result_lo = ready ? lo_q : 32'd0;
    result_hi = ready ? hi_q : 32'd0;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, signed/unsigned results,
// divide-by-zero, annul, reset mid-run, operand isolation and back-to-back use.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        annul;
  logic        stallreq;
  logic        ready;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        busy;

  int checks = 0;
  int failures = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .op_a(op_a), .op_b(op_b), .annul(annul), .stallreq(stallreq),
    .ready(ready), .result_lo(result_lo), .result_hi(result_hi), .busy(busy)
  );

  always #5 clk = ~clk;

  // Runs one divide from IDLE; cycle 0 is the first cycle start is high.
  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit scramble,
                         output int lat, output logic [31:0] lo, output logic [31:0] hi,
                         output bit stall_ok, output bit hold_ok, output bit idle_ok);
    lat = -1; lo = 32'd0; hi = 32'd0; stall_ok = 1'b1; hold_ok = 1'b1; idle_ok = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = sd; op_a = a; op_b = b;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = c; lo = result_lo; hi = result_hi;
        if (stallreq !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stallreq !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      if (scramble) begin
        op_a = 32'hDEADBEEF; op_b = 32'd0; signed_div = ~sd;
      end
    end
    if (lat < 0) begin
      start = 1'b0; annul = 1'b1;
      @(posedge clk); #1;
      annul = 1'b0;
      return;
    end
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      if (h == hold) start = 1'b0;
      @(negedge clk);
      if (ready !== 1'b1 || result_lo !== lo || result_hi !== hi || stallreq !== 1'b0)
        hold_ok = 1'b0;
    end
    @(posedge clk); #1;
    @(negedge clk);
    idle_ok = (busy === 1'b0 && ready === 1'b0 && result_lo === 32'd0 &&
               result_hi === 32'd0 && stallreq === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; annul = 1'b0; signed_div = 1'b0;
    op_a = 32'd5; op_b = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (stallreq !== 1'b0) begin failures++; $display("[TB] FAIL reset_stallreq got=%b exp=0", stallreq); end
    checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (result_lo !== 32'd0 || result_hi !== 32'd0) begin failures++; $display("[TB] FAIL reset_results got lo=%h hi=%h exp 0", result_lo, result_hi); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_divu_basic();
    int lat; logic [31:0] lo, hi; bit s_ok, h_ok, i_ok;
    run_div(1'b0, 32'd100, 32'd7, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL divu_latency got=%0d exp=33", lat); end
    checks++; if (lo !== 32'd14) begin failures++; $display("[TB] FAIL divu_lo got=%h exp=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin failures++; $display("[TB] FAIL divu_hi got=%h exp=00000002", hi); end
    checks++; if (s_ok !== 1'b1) begin failures++; $display("[TB] FAIL divu_stallreq got=%b exp=1", s_ok); end
    checks++; if (h_ok !== 1'b1) begin failures++; $display("[TB] FAIL divu_done_hold got=%b exp=1", h_ok); end
    checks++; if (i_ok !== 1'b1) begin failures++; $display("[TB] FAIL divu_return_idle got=%b exp=1", i_ok); end
  endtask

  task automatic test_signed();
    int lat; logic [31:0] lo, hi; bit s_ok, h_ok, i_ok;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL div_neg7_by_2 got lo=%h hi=%h exp lo=fffffffd hi=ffffffff", lo, hi); end
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin failures++; $display("[TB] FAIL div_7_by_neg2 got lo=%h hi=%h exp lo=fffffffd hi=00000001", lo, hi); end
    run_div(1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lo !== 32'd2 || hi !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL div_neg8_by_neg3 got lo=%h hi=%h exp lo=00000002 hi=fffffffe", lo, hi); end
  endtask

  task automatic test_divzero();
    int lat; logic [31:0] lo, hi; bit s_ok, h_ok, i_ok;
    run_div(1'b1, 32'd5, 32'd0, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL divzero_latency got=%0d exp=2", lat); end
    checks++; if (lo !== 32'd0 || hi !== 32'd0) begin failures++; $display("[TB] FAIL divzero_results got lo=%h hi=%h exp 0", lo, hi); end
    checks++; if (s_ok !== 1'b1 || i_ok !== 1'b1) begin failures++; $display("[TB] FAIL divzero_handshake got stall=%b idle=%b exp 1 1", s_ok, i_ok); end
  endtask

  task automatic test_boundaries();
    int lat; logic [31:0] lo, hi; bit s_ok, h_ok, i_ok;
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'd0) begin failures++; $display("[TB] FAIL divu_max_by_1 got lo=%h hi=%h exp lo=ffffffff hi=0", lo, hi); end
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL div_overflow_latency got=%0d exp=33", lat); end
    checks++; if (lo !== 32'h80000000 || hi !== 32'd0) begin failures++; $display("[TB] FAIL div_overflow got lo=%h hi=%h exp lo=80000000 hi=0", lo, hi); end
    run_div(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lo !== 32'd0 || hi !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL divu_small_by_max got lo=%h hi=%h exp lo=0 hi=fffffffe", lo, hi); end
  endtask

  task automatic test_start_annul_idle();
    bit moved = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; signed_div = 1'b0; op_a = 32'd10; op_b = 32'd2;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || stallreq !== 1'b0 || ready !== 1'b0) moved = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; annul = 1'b0;
    checks++; if (moved !== 1'b0) begin failures++; $display("[TB] FAIL start_annul_idle got left_idle=%b exp=0", moved); end
  endtask

  task automatic test_annul();
    int lat; logic [31:0] lo, hi; bit s_ok, h_ok, i_ok; bit seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    checks++; if (stallreq !== 1'b0) begin failures++; $display("[TB] FAIL annul_stallreq got=%b exp=0", stallreq); end
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL annul_to_idle got busy=%b exp=0", busy); end
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL annul_no_ready got=%b exp=0", seen); end
    run_div(1'b0, 32'd9, 32'd3, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lo !== 32'd3 || hi !== 32'd0) begin failures++; $display("[TB] FAIL annul_then_divu got lo=%h hi=%h exp lo=3 hi=0", lo, hi); end
  endtask

  task automatic test_reset_midrun();
    int lat; logic [31:0] lo, hi; bit s_ok, h_ok, i_ok; bit seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; op_a = 32'd100; op_b = 32'd7;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (stallreq !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_midrun_outputs got stall=%b busy=%b exp 0 0", stallreq, busy); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ready !== 1'b0 || result_lo !== 32'd0 || result_hi !== 32'd0) begin failures++; $display("[TB] FAIL rst_midrun_after got busy=%b ready=%b lo=%h hi=%h exp all 0", busy, ready, result_lo, result_hi); end
    repeat (20) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL rst_midrun_stale got=%b exp=0", seen); end
    run_div(1'b0, 32'd100, 32'd7, 0, 1'b1, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("[TB] FAIL operand_isolation got lo=%h hi=%h exp lo=e hi=2", lo, hi); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] lo, hi; bit s_ok, h_ok, i_ok;
    run_div(1'b0, 32'd50, 32'd5, 3, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lo !== 32'd10 || hi !== 32'd0) begin failures++; $display("[TB] FAIL b2b_first got lo=%h hi=%h exp lo=a hi=0", lo, hi); end
    checks++; if (h_ok !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done_hold got=%b exp=1", h_ok); end
    run_div(1'b0, 32'd9, 32'd4, 0, 1'b0, lat, lo, hi, s_ok, h_ok, i_ok);
    checks++; if (lat !== 33 || lo !== 32'd2 || hi !== 32'd1) begin failures++; $display("[TB] FAIL b2b_second got lat=%0d lo=%h hi=%h exp lat=33 lo=2 hi=1", lat, lo, hi); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_divzero();
    test_boundaries();
    test_start_annul_idle();
    test_annul();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
